// File: rtl/uart_hex_parser_pkg.sv
// uart_hex_parser_pkg: shared ASCII constants and FSM state encoding for the
// UART hex-line parser (uart_hex_parser and hex_ascii_decode).
package uart_hex_parser_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_UF = 8'h46;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_LF_HEX = 8'h66;  // lowercase 'f'

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    DISCARD = 2'd2
  } state_t;

endpackage

// File: rtl/uart_hex_parser_hex_ascii_decode.sv
// hex_ascii_decode: classifies one received ASCII byte.
//   code    in  8  received byte
//   nib     out 4  hex nibble value (0 when not hex)
//   is_hex  out 1  byte is a hex digit
//   is_term out 1  byte is CR or LF
// Config macro: HEX_PARSER_LOWER_EN - when defined, 'a'-'f' also decode as hex.
module hex_ascii_decode
  import uart_hex_parser_pkg::*;
(
  input  logic [7:0] code,
  output logic [3:0] nib,
  output logic       is_hex,
  output logic       is_term
);

  always_comb begin
    nib     = 4'h0;
    is_hex  = 1'b0;
    is_term = (code == ASCII_CR) || (code == ASCII_LF);
    if (code >= ASCII_0 && code <= ASCII_9) begin
      is_hex = 1'b1;
      nib    = code[3:0];
    end else if (code >= ASCII_UA && code <= ASCII_UF) begin
      // 'A' is 0x41: low nibble 1..6 maps to 10..15
      is_hex = 1'b1;
      nib    = code[3:0] + 4'd9;
    end
`ifdef HEX_PARSER_LOWER_EN
    else if (code >= ASCII_LA && code <= ASCII_LF_HEX) begin
      is_hex = 1'b1;
      nib    = code[3:0] + 4'd9;
    end
`else
`endif
  end

endmodule

// File: rtl/uart_hex_parser.sv
// uart_hex_parser: assembles ASCII hex lines ("ABCD\r\n") from the UART RX
// byte stream into a 16-bit value; malformed lines are flagged and dropped.
//   clk          in  1   clock
//   rst          in  1   synchronous reset, active low
//   rx_ready     in  1   byte available on rx_byte
//   rx_byte      in  8   received byte
//   rx_read      out 1   one-cycle pop strobe back to the RX side
//   value_out    out 16  last completed value (zero-extended)
//   value_valid  out 1   one-cycle pulse when value_out updates
//   digits_out   out 3   digit count of value_out
//   err          out 1   one-cycle pulse on bad char, overflow or timeout
// Config macro: HEX_PARSER_LOWER_EN (consumed inside hex_ascii_decode).
module uart_hex_parser
  import uart_hex_parser_pkg::*;
#(
  parameter int MAX_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_ready,
  input  logic [7:0]  rx_byte,
  output logic        rx_read,
  output logic [15:0] value_out,
  output logic        value_valid,
  output logic [2:0]  digits_out,
  output logic        err
);

  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam int TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_t        state, state_n, cur;
  logic [15:0]   acc, acc_n, value_n;
  logic [2:0]    dcnt, dcnt_n, digits_n;
  logic [TW-1:0] tmo, tmo_n;
  logic          take, fire, vld_n, err_n;
  logic [3:0]    nib;
  logic          is_hex, is_term;

  hex_ascii_decode u_dec (
    .code    (rx_byte),
    .nib     (nib),
    .is_hex  (is_hex),
    .is_term (is_term)
  );

  // rx_read is registered, so it doubles as the "just popped" flag that
  // blocks a second take in the following cycle.
  assign take = rx_ready && !rx_read;
  assign fire = TMO_EN && (state != IDLE) && (tmo == TMO_LAST);

  always_comb begin
    // A timeout abandons the line; a byte taken in the same cycle is then
    // handled as if the FSM were already back in IDLE.
    cur      = fire ? IDLE : state;
    state_n  = cur;
    acc_n    = fire ? 16'h0 : acc;
    dcnt_n   = fire ? 3'd0 : dcnt;
    err_n    = fire && !take && (state == ACCUM);
    vld_n    = 1'b0;
    value_n  = value_out;
    digits_n = digits_out;
    if (take) begin
      case (cur)
        IDLE: begin
          if (is_hex) begin
            acc_n   = {12'h0, nib};
            dcnt_n  = 3'd1;
            state_n = ACCUM;
          end else if (!is_term) begin
            err_n   = 1'b1;
            state_n = DISCARD;
          end
        end
        ACCUM: begin
          if (is_hex && dcnt < 3'(MAX_DIGITS)) begin
            acc_n  = {acc[11:0], nib};
            dcnt_n = dcnt + 3'd1;
          end else if (is_term) begin
            value_n  = acc;
            digits_n = dcnt;
            vld_n    = 1'b1;
            acc_n    = 16'h0;
            dcnt_n   = 3'd0;
            state_n  = IDLE;
          end else begin
            // bad char or one digit too many
            err_n   = 1'b1;
            acc_n   = 16'h0;
            dcnt_n  = 3'd0;
            state_n = DISCARD;
          end
        end
        DISCARD: begin
          if (is_term) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
    tmo_n = (!TMO_EN || take || state_n == IDLE) ? '0 : tmo + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      acc         <= 16'h0;
      dcnt        <= 3'd0;
      tmo         <= '0;
      rx_read     <= 1'b0;
      value_out   <= 16'h0;
      value_valid <= 1'b0;
      digits_out  <= 3'd0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      dcnt        <= dcnt_n;
      tmo         <= tmo_n;
      rx_read     <= take;
      value_out   <= value_n;
      value_valid <= vld_n;
      digits_out  <= digits_n;
      err         <= err_n;
    end
  end

endmodule

// File: tb/tb_uart_hex_parser.sv
// Scoreboard bench for uart_hex_parser: a byte FIFO models the UART RX side,
// stimulus pushes expected events, a monitor pops and compares on each pulse.
// In send(), '^' stands for CR and '~' for LF.
module tb_uart_hex_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_read;
  logic [15:0] value_out;
  logic        value_valid;
  logic [2:0]  digits_out;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_err;
    logic [15:0] val;
    logic [2:0]  dig;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo[$];

  uart_hex_parser #(.MAX_DIGITS(4), .TIMEOUT_CYCLES(100)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_ready    (rx_ready),
    .rx_byte     (rx_byte),
    .rx_read     (rx_read),
    .value_out   (value_out),
    .value_valid (value_valid),
    .digits_out  (digits_out),
    .err         (err)
  );

  always #5 clk = ~clk;

  // UART RX model: pop on rx_read, present the next byte immediately
  initial forever begin
    @(negedge clk);
    if (rx_read && fifo.size() > 0) void'(fifo.pop_front());
    rx_ready = (fifo.size() > 0);
    rx_byte  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  end

  // monitor
  initial begin
    logic prev_rd;
    exp_t e;
    prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_read) begin
        checks++;
        if (prev_rd) begin
          errors++;
          $display("FAIL rx_read_consecutive: got two cycles high, need one");
        end
      end
      prev_rd = rx_read;
      if (err && value_valid) begin
        errors++;
        $display("FAIL err_and_valid: both high, need at most one");
      end
      if (value_valid || err) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: valid=%0b err=%0b value=%h, none expected",
                   value_valid, err, value_out);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err && !err) begin
            errors++;
            $display("FAIL event_kind: got value %h/%0d, need err", value_out, digits_out);
          end else if (!e.is_err && !value_valid) begin
            errors++;
            $display("FAIL event_kind: got err, need value %h/%0d", e.val, e.dig);
          end else if (!e.is_err && (value_out !== e.val || digits_out !== e.dig)) begin
            errors++;
            $display("FAIL value: got %h/%0d, need %h/%0d", value_out, digits_out, e.val, e.dig);
          end
        end
      end
    end
  end

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "^")      fifo.push_back(8'h0D);
      else if (s[i] == "~") fifo.push_back(8'h0A);
      else                  fifo.push_back(8'(s[i]));
    end
  endtask

  task automatic exp_v(input logic [15:0] v, input logic [2:0] d);
    exp_t e;
    e.is_err = 1'b0; e.val = v; e.dig = d;
    exp_q.push_back(e);
  endtask

  task automatic exp_e();
    exp_t e;
    e.is_err = 1'b1; e.val = 16'h0; e.dig = 3'd0;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((fifo.size() > 0 || exp_q.size() > 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) begin
      checks++;
      errors++;
      $display("FAIL drain_%s: %0d events outstanding, need 0", name, exp_q.size());
      exp_q.delete();
      fifo.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic check_reset(input string name);
    checks++;
    if (value_out !== 16'h0 || digits_out !== 3'd0 || value_valid !== 1'b0 ||
        err !== 1'b0 || rx_read !== 1'b0) begin
      errors++;
      $display("FAIL %s: value=%h dig=%0d vld=%0b err=%0b rd=%0b, need all 0",
               name, value_out, digits_out, value_valid, err, rx_read);
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset_state");
    rst = 1'b1;

    send("ABCD^~");  exp_v(16'hABCD, 3'd4); drain("abcd");
    send("7F~");     exp_v(16'h007F, 3'd2); drain("7f");
    send("^^");      drain("cr_only");
    send("12345^0009~"); exp_e(); exp_v(16'h0009, 3'd4); drain("overflow");
    send("1G2^");    exp_e(); drain("bad_char");
    checks++;
    if (value_out !== 16'h0009) begin
      errors++;
      $display("FAIL value_hold: got %h, need 0009", value_out);
    end
    send("0^");      exp_v(16'h0000, 3'd1); drain("zero");
    send("FFFF^");   exp_v(16'hFFFF, 3'd4); drain("ffff");
    send("xyz^");    exp_e(); drain("multi_bad");

    // timeout from ACCUM
    send("12");      exp_e(); drain("timeout_accum");
    send("3^");      exp_v(16'h0003, 3'd1); drain("after_timeout");

    // timeout from DISCARD is silent
    send("G");       exp_e(); drain("discard_enter");
    repeat (120) @(negedge clk);
    send("5^");      exp_v(16'h0005, 3'd1); drain("after_discard_tmo");

    // reset mid-line
    send("AB");      drain("partial");
    rst = 1'b0;
    @(negedge clk);
    check_reset("midline_reset");
    rst = 1'b1;
    send("C^");      exp_v(16'h000C, 3'd1); drain("after_reset");

    send("beef^");
`ifdef HEX_PARSER_LOWER_EN
    exp_v(16'hBEEF, 3'd4);
`else
    exp_e();
`endif
    drain("lowercase");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
